// File: rtl/clock_display.sv
// Six-digit multiplexed HH:MM:SS seven-segment driver with frame-synchronous input capture.
// Optional build macro LEAD_ZERO_BLANK_EN blanks a leading zero in the hours-tens digit.
module clock_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hrcount,
  input  logic [7:0] mincount,
  input  logic [7:0] secondcount,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [23:0] PCNT_LAST = 24'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [5:0]  AN_OFF    = 6'b111111;

  // Segment pattern for one decimal digit, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  function automatic logic [3:0] tens_of(input logic [7:0] value);
    logic [7:0] quot;
    quot = value / 8'd10;
    return quot[3:0];
  endfunction

  function automatic logic [3:0] units_of(input logic [7:0] value);
    logic [7:0] rem;
    rem = value % 8'd10;
    return rem[3:0];
  endfunction

  logic [23:0] pcnt_q, pcnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  hr_q, hr_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  sec_q, sec_d;
  logic [5:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        pcnt_wrap_s;
  logic        frame_load_s;
  logic        blank_cycle_s;
  logic        lead_blank_s;
  logic [7:0]  field_s;
  logic [3:0]  digit_s;

  // Prescaler, slot index and frame-start shadow capture.
  always_comb begin
    pcnt_d       = pcnt_q;
    idx_d        = idx_q;
    hr_d         = hr_q;
    min_d        = min_q;
    sec_d        = sec_q;
    pcnt_wrap_s  = (pcnt_q == PCNT_LAST);
    frame_load_s = (idx_q == 3'd0) && (pcnt_q == 24'd0);

    if (pcnt_wrap_s) begin
      pcnt_d = 24'd0;
      if (idx_q >= 3'd5) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      pcnt_d = pcnt_q + 24'd1;
      idx_d  = idx_q;
    end

    // Inputs are sampled once per frame so a digit pair never tears.
    if (frame_load_s) begin
      hr_d  = hrcount;
      min_d = mincount;
      sec_d = secondcount;
    end else begin
      hr_d  = hr_q;
      min_d = min_q;
      sec_d = sec_q;
    end
  end

  // Digit selection and next output pattern for the current slot.
  always_comb begin
    an_d          = AN_OFF;
    seg_d         = SEG_BLANK;
    dp_d          = 1'b1;
    field_s       = 8'd0;
    digit_s       = 4'd0;
    lead_blank_s  = 1'b0;
    blank_cycle_s = (pcnt_q == 24'd0);

    case (idx_q)
      3'd0, 3'd1: field_s = sec_q;
      3'd2, 3'd3: field_s = min_q;
      3'd4, 3'd5: field_s = hr_q;
      default:    field_s = 8'd0;
    endcase

    // Odd slots carry the tens digit of their field.
    if (idx_q[0]) begin
      digit_s = tens_of(field_s);
    end else begin
      digit_s = units_of(field_s);
    end

`ifdef LEAD_ZERO_BLANK_EN
    lead_blank_s = (idx_q == 3'd5) && (field_s <= 8'd99) && (digit_s == 4'd0);
`else
    lead_blank_s = 1'b0;
`endif

    if (blank_cycle_s) begin
      an_d = AN_OFF;
    end else begin
      case (idx_q)
        3'd0:    an_d = 6'b111110;
        3'd1:    an_d = 6'b111101;
        3'd2:    an_d = 6'b111011;
        3'd3:    an_d = 6'b110111;
        3'd4:    an_d = 6'b101111;
        3'd5:    an_d = 6'b011111;
        default: an_d = AN_OFF;
      endcase
    end

    if (blank_cycle_s) begin
      seg_d = SEG_BLANK;
    end else if (field_s > 8'd99) begin
      seg_d = SEG_DASH;
    end else if (lead_blank_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_encode(digit_s);
    end

    // Separator dots sit right of the minutes-units and hours-units digits.
    if (!blank_cycle_s && ((idx_q == 3'd2) || (idx_q == 3'd4))) begin
      dp_d = 1'b0;
    end else begin
      dp_d = 1'b1;
    end
  end

  // State and registered display outputs; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= 24'd0;
      idx_q  <= 3'd0;
      hr_q   <= 8'd0;
      min_q  <= 8'd0;
      sec_q  <= 8'd0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      hr_q   <= hr_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display.sv
// Scoreboard bench for clock_display at SCAN_DIV=4: stimulus queues expected per-cycle
// outputs, a monitor compares each sampled cycle on the falling edge.
module tb_clock_display;

  logic       clk;
  logic       rst;
  logic [7:0] hrcount;
  logic [7:0] mincount;
  logic [7:0] secondcount;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests_run = 0;
  int tests_failed = 0;
  int sample_no = 0;
  logic [13:0] exp_q[$];

  clock_display #(.SCAN_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .hrcount(hrcount),
    .mincount(mincount),
    .secondcount(secondcount),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {an,seg,dp} for frame cycle s (4 cycles per slot, first one blank).
  function automatic logic [13:0] exp_out(input int hr, input int mn, input int sc, input int s);
    int slot;
    int ph;
    int v;
    int d;
    logic [5:0] a;
    logic [6:0] sg;
    logic dpv;
    slot = s / 4;
    ph = s % 4;
    if (ph == 0) return {6'b111111, 7'b1111111, 1'b1};
    v = (slot < 2) ? sc : ((slot < 4) ? mn : hr);
    d = (slot % 2 == 1) ? (v / 10) : (v % 10);
    a = 6'b111111;
    a[slot] = 1'b0;
    if (v > 99) sg = 7'b0111111;
    else sg = digit_pat(d);
`ifdef LEAD_ZERO_BLANK_EN
    if (slot == 5 && v <= 99 && d == 0) sg = 7'b1111111;
`endif
    dpv = (slot == 2 || slot == 4) ? 1'b0 : 1'b1;
    return {a, sg, dpv};
  endfunction

  // Monitor: one output cycle checked per falling edge while expectations are queued.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if ({an, seg, dp} !== e) begin
          tests_failed++;
          $display("FAIL out_cycle[%0d] got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   sample_no, an, seg, dp, e[13:8], e[7:1], e[0]);
        end
        sample_no++;
      end
    end
  end

  task automatic push_blank(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({6'b111111, 7'b1111111, 1'b1});
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic run_frame(input int hr, input int mn, input int sc, input int ncyc,
                           input bit chg, input int new_sec);
    hrcount = 8'(hr);
    mincount = 8'(mn);
    secondcount = 8'(sc);
    for (int s = 0; s < ncyc; s++) exp_q.push_back(exp_out(hr, mn, sc, s));
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      #2;
      if (chg && c == 9) secondcount = 8'(new_sec);
    end
  endtask

  initial begin
    rst = 1'b0;
    hrcount = 8'd0;
    mincount = 8'd0;
    secondcount = 8'd0;
    push_blank(3);
    rst = 1'b1;
    run_frame(12, 34, 56, 24, 1'b0, 0);
    run_frame(12, 34, 56, 24, 1'b1, 57);
    run_frame(12, 34, 57, 24, 1'b0, 0);
    run_frame(12, 120, 57, 24, 1'b0, 0);
    run_frame(5, 34, 56, 24, 1'b0, 0);
    run_frame(99, 100, 0, 24, 1'b0, 0);
    run_frame(0, 59, 9, 24, 1'b0, 0);
    run_frame(12, 34, 56, 10, 1'b0, 0);
    rst = 1'b0;
    push_blank(3);
    rst = 1'b1;
    run_frame(23, 45, 6, 24, 1'b0, 0);
    @(negedge clk);
    #3;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
